// File: rtl/datapath_gen2_pipe_if.sv
// Bus bundle between the microsequencer/memory side and datapath_gen2_pipe.
// Carries the MIR fields, IR, memory handshake, and the datapath read/flag outputs.
//  master : drives MIR/IR/memory inputs, observes A/B/DataOut/Flags/Busy
//  slave  : the datapath itself
interface datapath_gen2_pipe_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          DPG_Issue_In;
  logic          DPG_Busy_Out;
  logic [AW-1:0] DPG_DirA_InBus;
  logic [AW-1:0] DPG_DirB_InBus;
  logic [AW-1:0] DPG_DirC_InBus;
  logic          DPG_SelectA_In;
  logic          DPG_SelectB_In;
  logic          DPG_SelectC_In;
  logic [DW-1:0] DPG_IR_InBus;
  logic          DPG_RD_In;
  logic [DW-1:0] DPG_MemoryData_InBus;
  logic          DPG_MemValid_In;
  logic [2:0]    DPG_ALUOperation_InBus;
  logic          DPG_SetCode_In;
  logic [DW-1:0] DPG_A_OutBus;
  logic [DW-1:0] DPG_B_OutBus;
  logic [DW-1:0] DPG_DataOut_OutBus;
  logic [3:0]    DPG_Flags_OutBus;

  modport master (
    output DPG_Issue_In, DPG_DirA_InBus, DPG_DirB_InBus, DPG_DirC_InBus,
           DPG_SelectA_In, DPG_SelectB_In, DPG_SelectC_In, DPG_IR_InBus, DPG_RD_In,
           DPG_MemoryData_InBus, DPG_MemValid_In, DPG_ALUOperation_InBus, DPG_SetCode_In,
    input  DPG_Busy_Out, DPG_A_OutBus, DPG_B_OutBus, DPG_DataOut_OutBus, DPG_Flags_OutBus
  );

  modport slave (
    input  DPG_Issue_In, DPG_DirA_InBus, DPG_DirB_InBus, DPG_DirC_InBus,
           DPG_SelectA_In, DPG_SelectB_In, DPG_SelectC_In, DPG_IR_InBus, DPG_RD_In,
           DPG_MemoryData_InBus, DPG_MemValid_In, DPG_ALUOperation_InBus, DPG_SetCode_In,
    output DPG_Busy_Out, DPG_A_OutBus, DPG_B_OutBus, DPG_DataOut_OutBus, DPG_Flags_OutBus
  );
endinterface

// File: rtl/datapath_gen2_pipe.sv
// Second-generation microcoded datapath: parametrised register file with read-only
// constant low registers, two combinational read ports with write-back bypass, 8-op ALU,
// registered write-back stage, registered {N,Z,V,C} flags, and a memory-load wait FSM.
// Ports:
//  DPG_CLOCK_50        clock, rising edge
//  DPG_ResetInHigh_In  asynchronous active-high reset
//  bus (slave)         MIR/IR/memory inputs; A/B/DataOut/Flags/Busy outputs
module datapath_gen2_pipe #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int NUM_REGS       = 32,
  parameter int DATAWIDTH_ADDR = 5,
  parameter int NUM_FIXED      = 2,
  parameter int OUT_REG_INDEX  = 4
) (
  input  logic                DPG_CLOCK_50,
  input  logic                DPG_ResetInHigh_In,
  datapath_gen2_pipe_if.slave bus
);
  localparam int DW = DATAWIDTH_BUS;
  localparam int AW = DATAWIDTH_ADDR;
  localparam logic [AW-1:0] FIXED_A = AW'(NUM_FIXED);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW-1:0] OUT_A   = AW'(OUT_REG_INDEX);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_MEM = 1'b1;

  logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic          wb_vld_q, wb_vld_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [3:0]    flags_q, flags_d;

  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [DW-1:0] opa, opb, alu_res;
  logic [DW:0]   sum_w;
  logic [DW-1:0] diff_w;
  logic [4:0]    shamt;
  logic          alu_v, alu_c, busy, accepted;

  // Fixed registers win over everything; then a pending WB entry shadows the array.
  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
    if (a < FIXED_A)                        return (a == ONE_A) ? DW'(1) : '0;
    else if (wb_vld_q && wb_addr_q == a)    return wb_data_q;
    else                                    return regs_q[a];
  endfunction

  always_comb begin
    addr_a = bus.DPG_SelectA_In ? AW'(bus.DPG_IR_InBus[18:14]) : bus.DPG_DirA_InBus;
    addr_b = bus.DPG_SelectB_In ? AW'(bus.DPG_IR_InBus[4:0])   : bus.DPG_DirB_InBus;
    addr_c = bus.DPG_SelectC_In ? AW'(bus.DPG_IR_InBus[29:25]) : bus.DPG_DirC_InBus;
    opa    = rd_port(addr_a);
    opb    = rd_port(addr_b);
  end

  always_comb begin
    sum_w   = {1'b0, opa} + {1'b0, opb};
    diff_w  = opa - opb;
    shamt   = opb[4:0];
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (bus.DPG_ALUOperation_InBus)
      3'd0: begin
        alu_res = sum_w[DW-1:0];
        alu_c   = sum_w[DW];
        alu_v   = (opa[DW-1] == opb[DW-1]) && (alu_res[DW-1] != opa[DW-1]);
      end
      3'd1: begin
        alu_res = diff_w;
        alu_c   = opa < opb;
        alu_v   = (opa[DW-1] != opb[DW-1]) && (alu_res[DW-1] != opa[DW-1]);
      end
      3'd2:    alu_res = opa & opb;
      3'd3:    alu_res = opa | opb;
      3'd4:    alu_res = opa ^ opb;
      3'd5:    alu_res = opa;
      3'd6:    alu_res = opa << shamt;   // amounts >= DW shift everything out
      default: alu_res = opa >> shamt;
    endcase
  end

  assign busy     = (state_q == S_WAIT_MEM);
  assign accepted = bus.DPG_Issue_In & ~busy;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    wb_vld_d    = 1'b0;          // WB lives one cycle unless recaptured
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    flags_d     = flags_q;
    regs_d      = regs_q;
    // Writes to fixed addresses still occupy WB but never land in the array.
    if (wb_vld_q && wb_addr_q >= FIXED_A) regs_d[wb_addr_q] = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (accepted) begin
          if (!bus.DPG_RD_In) begin
            wb_vld_d  = 1'b1;
            wb_addr_d = addr_c;
            wb_data_d = alu_res;
            if (bus.DPG_SetCode_In) flags_d = {alu_res[DW-1], ~|alu_res, alu_v, alu_c};
          end else if (bus.DPG_MemValid_In) begin
            wb_vld_d  = 1'b1;
            wb_addr_d = addr_c;
            wb_data_d = bus.DPG_MemoryData_InBus;
          end else begin
            pend_addr_d = addr_c;
            state_d     = S_WAIT_MEM;
          end
        end
      end
      default: begin
        if (bus.DPG_MemValid_In) begin
          wb_vld_d  = 1'b1;
          wb_addr_d = pend_addr_q;
          wb_data_d = bus.DPG_MemoryData_InBus;
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge DPG_CLOCK_50 or posedge DPG_ResetInHigh_In) begin
    if (DPG_ResetInHigh_In) begin
      regs_q      <= '0;
      state_q     <= S_IDLE;
      pend_addr_q <= '0;
      wb_vld_q    <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      flags_q     <= '0;
    end else begin
      regs_q      <= regs_d;
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      wb_vld_q    <= wb_vld_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.DPG_A_OutBus       = opa;
  assign bus.DPG_B_OutBus       = opb;
  assign bus.DPG_DataOut_OutBus = regs_q[OUT_A];
  assign bus.DPG_Flags_OutBus   = flags_q;
  assign bus.DPG_Busy_Out       = busy;
endmodule

// File: tb/tb_datapath_gen2_pipe.sv
module tb_datapath_gen2_pipe;
  localparam int DW = 32, AW = 5, NR = 32, OUTR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  datapath_gen2_pipe_if #(.DW(DW), .AW(AW)) bus();

  datapath_gen2_pipe #(.DATAWIDTH_BUS(DW), .NUM_REGS(NR), .DATAWIDTH_ADDR(AW),
                       .NUM_FIXED(2), .OUT_REG_INDEX(OUTR))
    dut (.DPG_CLOCK_50(clk), .DPG_ResetInHigh_In(rst), .bus(bus.slave));

  // Reference model: architectural register contents, one pending write, load wait.
  logic [31:0] m_reg [NR];
  bit          pv;
  int          pa;
  logic [31:0] pd;
  bit          mbusy;
  int          la;
  logic [3:0]  mflags;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] m_rd(input int a);
    if (a == 0) return 32'd0;
    if (a == 1) return 32'd1;
    if (pv && pa == a) return pd;
    return m_reg[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    pv = 0; mbusy = 0; mflags = '0; pa = 0; pd = '0; la = 0;
  endtask

  // ALU and flag rules in plain wide arithmetic.
  task automatic alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [3:0] f);
    longint u, s;
    bit v, c;
    v = 0; c = 0; res = '0;
    case (op)
      3'd0: begin
        u = longint'(a) + longint'(b); res = u[31:0]; c = (u > 64'hFFFF_FFFF);
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        res = a - b; c = (a < b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = a;
      3'd6: res = a << b[4:0];
      default: res = a >> b[4:0];
    endcase
    f = {res[31], res == 32'd0, v, c};
  endtask

  function automatic int sel_a();
    return bus.DPG_SelectA_In ? int'(bus.DPG_IR_InBus[18:14]) : int'(bus.DPG_DirA_InBus);
  endfunction
  function automatic int sel_b();
    return bus.DPG_SelectB_In ? int'(bus.DPG_IR_InBus[4:0]) : int'(bus.DPG_DirB_InBus);
  endfunction
  function automatic int sel_c();
    return bus.DPG_SelectC_In ? int'(bus.DPG_IR_InBus[29:25]) : int'(bus.DPG_DirC_InBus);
  endfunction

  // Compare all outputs against the model, mid-cycle.
  task automatic look();
    #3;
    if (rst) m_reset();
    chk("A_OutBus", bus.DPG_A_OutBus, m_rd(sel_a()));
    chk("B_OutBus", bus.DPG_B_OutBus, m_rd(sel_b()));
    chk("DataOut", bus.DPG_DataOut_OutBus, m_reg[OUTR]);
    chk("Flags", {28'd0, bus.DPG_Flags_OutBus}, {28'd0, mflags});
    chk("Busy", {31'd0, bus.DPG_Busy_Out}, {31'd0, mbusy});
  endtask

  // Advance one clock edge, updating the model with the inputs present before the edge.
  task automatic adv();
    logic [31:0] res, mem;
    logic [3:0]  f;
    bit acc, rd, mv, sc;
    int c;
    alu_model(bus.DPG_ALUOperation_InBus, m_rd(sel_a()), m_rd(sel_b()), res, f);
    acc = bus.DPG_Issue_In && !mbusy;
    rd  = bus.DPG_RD_In; mv = bus.DPG_MemValid_In; sc = bus.DPG_SetCode_In;
    mem = bus.DPG_MemoryData_InBus; c = sel_c();
    @(posedge clk);
    if (rst) m_reset();
    else begin
      if (pv && pa >= 2) m_reg[pa] = pd;
      pv = 0;
      if (mbusy) begin
        if (mv) begin pv = 1; pa = la; pd = mem; mbusy = 0; end
      end else if (acc) begin
        if (!rd) begin
          pv = 1; pa = c; pd = res;
          if (sc) mflags = f;
        end else if (mv) begin pv = 1; pa = c; pd = mem; end
        else begin mbusy = 1; la = c; end
      end
    end
    #1;
  endtask

  task automatic idle_in();
    bus.DPG_Issue_In = 0; bus.DPG_DirA_InBus = '0; bus.DPG_DirB_InBus = '0;
    bus.DPG_DirC_InBus = '0; bus.DPG_SelectA_In = 0; bus.DPG_SelectB_In = 0;
    bus.DPG_SelectC_In = 0; bus.DPG_IR_InBus = '0; bus.DPG_RD_In = 0;
    bus.DPG_MemoryData_InBus = '0; bus.DPG_MemValid_In = 0;
    bus.DPG_ALUOperation_InBus = '0; bus.DPG_SetCode_In = 0;
  endtask

  task automatic alu_issue(input logic [2:0] op, input int a, input int b, input int c,
                           input bit sc);
    idle_in();
    bus.DPG_Issue_In = 1; bus.DPG_ALUOperation_InBus = op; bus.DPG_SetCode_In = sc;
    bus.DPG_DirA_InBus = AW'(a); bus.DPG_DirB_InBus = AW'(b); bus.DPG_DirC_InBus = AW'(c);
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    int bcnt;
    m_reset();
    idle_in();

    // Pin the model with hand-computed values.
    alu_model(3'd0, 32'h7FFF_FFFF, 32'd1, r, f);
    chk("model_add_res", r, 32'h8000_0000);
    chk("model_add_flags", {28'd0, f}, 32'hA);
    alu_model(3'd1, 32'd0, 32'd1, r, f);
    chk("model_sub_flags", {28'd0, f}, 32'h9);
    alu_model(3'd6, 32'h3, 32'd31, r, f);
    chk("model_sll", r, 32'h8000_0000);

    look(); adv(); look(); adv();
    rst = 0;

    // 1: reset state of every register
    for (int a = 0; a < NR; a++) begin
      bus.DPG_DirA_InBus = AW'(a); bus.DPG_DirB_InBus = AW'(NR - 1 - a);
      look();
      chk("t1_reg", bus.DPG_A_OutBus, (a == 1) ? 32'd1 : 32'd0);
      adv();
    end
    chk("t1_flags", {28'd0, bus.DPG_Flags_OutBus}, 32'd0);
    chk("t1_dataout", bus.DPG_DataOut_OutBus, 32'd0);

    // 2: bypass of a dependent issue
    alu_issue(3'd0, 1, 1, 5, 0); look(); adv();
    alu_issue(3'd5, 5, 0, 9, 0); look();
    chk("t2_bypass", bus.DPG_A_OutBus, 32'd2); adv();
    idle_in(); bus.DPG_DirA_InBus = 5; look(); adv(); look();
    chk("t2_r5", bus.DPG_A_OutBus, 32'd2); adv();

    // 3: fixed register write discarded
    alu_issue(3'd0, 1, 1, 0, 0); look(); adv();
    idle_in(); look();
    chk("t3_r0", bus.DPG_A_OutBus, 32'd0); adv();

    // 4: load wait; issue ignored while busy
    idle_in(); bus.DPG_Issue_In = 1; bus.DPG_RD_In = 1; bus.DPG_DirC_InBus = 6;
    look(); adv();
    bcnt = 0;
    for (int i = 0; i < 2; i++) begin
      alu_issue(3'd0, 1, 1, 7, 1); look();
      if (bus.DPG_Busy_Out) bcnt++;
      adv();
    end
    idle_in(); bus.DPG_MemValid_In = 1; bus.DPG_MemoryData_InBus = 32'hDEAD_BEEF; look();
    if (bus.DPG_Busy_Out) bcnt++;
    adv();
    idle_in(); bus.DPG_DirA_InBus = 6; bus.DPG_DirB_InBus = 7; look();
    if (bus.DPG_Busy_Out) bcnt++;
    chk("t4_busy_cycles", bcnt, 3);
    chk("t4_r6", bus.DPG_A_OutBus, 32'hDEAD_BEEF);
    chk("t4_r7_ignored", bus.DPG_B_OutBus, 32'd0);
    adv();

    // 5: condition codes
    alu_issue(3'd1, 1, 1, 0, 1); look(); adv(); look();
    chk("t5_sub_z", {28'd0, bus.DPG_Flags_OutBus}, 32'h4); adv();
    idle_in(); bus.DPG_Issue_In = 1; bus.DPG_RD_In = 1; bus.DPG_MemValid_In = 1;
    bus.DPG_DirC_InBus = 5; bus.DPG_MemoryData_InBus = 32'h7FFF_FFFF; look(); adv();
    alu_issue(3'd0, 5, 1, 0, 1); look(); adv(); look();
    chk("t5_add_nv", {28'd0, bus.DPG_Flags_OutBus}, 32'hA); adv();
    alu_issue(3'd1, 0, 1, 0, 1); look(); adv(); look();
    chk("t5_sub_nc", {28'd0, bus.DPG_Flags_OutBus}, 32'h9); adv();

    // 6: reset during WAIT_MEM drops the load
    idle_in(); bus.DPG_Issue_In = 1; bus.DPG_RD_In = 1; bus.DPG_DirC_InBus = 9;
    look(); adv();
    idle_in(); look();
    chk("t6_busy_before", {31'd0, bus.DPG_Busy_Out}, 32'd1);
    rst = 1; look();
    chk("t6_busy_reset", {31'd0, bus.DPG_Busy_Out}, 32'd0); adv();
    rst = 0; bus.DPG_MemValid_In = 1; bus.DPG_MemoryData_InBus = 32'h1234; look(); adv();
    idle_in(); bus.DPG_DirA_InBus = 9; look();
    chk("t6_r9", bus.DPG_A_OutBus, 32'd0); adv();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.DPG_Issue_In = ($urandom_range(0, 3) != 0);
      bus.DPG_DirA_InBus = AW'($urandom_range(0, NR - 1));
      bus.DPG_DirB_InBus = AW'($urandom_range(0, NR - 1));
      bus.DPG_DirC_InBus = AW'($urandom_range(0, 7));
      bus.DPG_SelectA_In = ($urandom_range(0, 3) == 0);
      bus.DPG_SelectB_In = ($urandom_range(0, 3) == 0);
      bus.DPG_SelectC_In = ($urandom_range(0, 3) == 0);
      bus.DPG_IR_InBus = $urandom();
      bus.DPG_RD_In = ($urandom_range(0, 4) == 0);
      bus.DPG_MemValid_In = $urandom_range(0, 1);
      bus.DPG_MemoryData_InBus = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom();
      bus.DPG_ALUOperation_InBus = 3'($urandom_range(0, 7));
      bus.DPG_SetCode_In = $urandom_range(0, 1);
      rst = ($urandom_range(0, 299) == 0);
      look(); adv();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
